// File: rtl/tile_pkg.sv
// Shared constants for the 2048 tile move engine: widths, direction codes,
// FSM state encoding and the cell addressing helper used when walking lines.
package tile_pkg;

    localparam int TILE_W  = 12;
    localparam int N_CELLS = 16;
    localparam int BOARD_W = TILE_W * N_CELLS;

    localparam logic [TILE_W-1:0] WIN_VALUE = 12'd2048;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MOVE  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_SPAWN = 3'd3;
    localparam logic [2:0] ST_FLAGS = 3'd4;

    // Cell index of position pos (0 = destination edge) within line for a direction.
    function automatic logic [3:0] cell_index(input logic [1:0] dir, input logic [1:0] line,
                                              input logic [1:0] pos);
        case (dir)
            DIR_UP:   cell_index = {pos, line};
            DIR_DOWN: cell_index = {~pos, line};
            DIR_LEFT: cell_index = {line, pos};
            default:  cell_index = {line, ~pos};
        endcase
    endfunction

endpackage

// File: rtl/tile_move_engine_line_merge4.sv
// Combinational 2048 line merge: compacts toward position 0, then merges equal
// neighbours once each, scanning from position 0.
module line_merge4 #(
    parameter int TILE_W = 12
) (
    input  logic [4*TILE_W-1:0] line_in,
    output logic [4*TILE_W-1:0] line_out,
    output logic                changed,
    output logic [12:0]         merge_sum
);

    logic [TILE_W-1:0] comp [5];
    logic [TILE_W-1:0] res  [4];
    logic [TILE_W-1:0] dbl;
    logic [2:0]        n;
    logic [2:0]        m;
    logic              skip;

    always_comb begin
        for (int k = 0; k < 5; k++) comp[k] = '0;
        for (int k = 0; k < 4; k++) res[k] = '0;
        n         = '0;
        m         = '0;
        skip      = 1'b0;
        dbl       = '0;
        merge_sum = '0;

        for (int k = 0; k < 4; k++) begin
            if (line_in[k*TILE_W +: TILE_W] != '0) begin
                comp[n] = line_in[k*TILE_W +: TILE_W];
                n       = n + 3'd1;
            end
        end

        // comp[4] stays zero so the last position never finds a partner
        for (int k = 0; k < 4; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else begin
                if (comp[k] != '0 && comp[k] == comp[k+1]) begin
                    dbl       = comp[k] << 1;
                    res[m]    = dbl;
                    merge_sum = merge_sum + 13'(dbl);
                    skip      = 1'b1;
                end else begin
                    res[m] = comp[k];
                end
                m = m + 3'd1;
            end
        end

        for (int k = 0; k < 4; k++) line_out[k*TILE_W +: TILE_W] = res[k];
        changed = (line_out != line_in);
    end

endmodule

// File: rtl/tile_move_engine.sv
// 2048 board owner: applies slide/merge moves one line per cycle, spawns random
// tiles after changing moves and maintains score, win and game_over.
module tile_move_engine #(
    parameter int          TILE_W    = 12,
    parameter int          WIN_VALUE = 2048,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   board_clk,
    input  logic                   reset,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   load_en,
    input  logic [16*TILE_W-1:0]   load_data,
    output logic [16*TILE_W-1:0]   MatrixCopy,
    output logic                   busy,
    output logic [19:0]            score,
    output logic                   win,
    output logic                   game_over
);
    import tile_pkg::N_CELLS;
    import tile_pkg::LFSR_TAPS;
    import tile_pkg::cell_index;
    import tile_pkg::DIR_UP;
    import tile_pkg::DIR_DOWN;
    import tile_pkg::DIR_LEFT;
    import tile_pkg::DIR_RIGHT;
    import tile_pkg::ST_IDLE;
    import tile_pkg::ST_MOVE;
    import tile_pkg::ST_CHECK;
    import tile_pkg::ST_SPAWN;
    import tile_pkg::ST_FLAGS;

    logic [TILE_W-1:0]   cells [N_CELLS];
    logic [2:0]          state;
    logic [1:0]          dir;
    logic [1:0]          line;
    logic                changed;
    logic [1:0]          spawn_left;
    logic                spawn_first;
    logic [3:0]          ptr;
    logic [3:0]          probes;
    logic [15:0]         lfsr;

    logic [4*TILE_W-1:0] line_in;
    logic [4*TILE_W-1:0] line_out;
    logic                line_changed;
    logic [12:0]         merge_sum;
    logic [20:0]         score_sum;
    logic [TILE_W-1:0]   spawn_val;
    logic                win_hit;
    logic                any_empty;
    logic                any_pair;

    always_comb begin
        for (int k = 0; k < 4; k++) line_in[k*TILE_W +: TILE_W] = cells[cell_index(dir, line, 2'(k))];
        for (int i = 0; i < N_CELLS; i++) MatrixCopy[i*TILE_W +: TILE_W] = cells[i];
    end

    line_merge4 #(.TILE_W(TILE_W)) u_merge (
        .line_in   (line_in),
        .line_out  (line_out),
        .changed   (line_changed),
        .merge_sum (merge_sum)
    );

    assign score_sum = {1'b0, score} + 21'(merge_sum);
    assign spawn_val = (lfsr[7:4] == 4'd0) ? TILE_W'(4) : TILE_W'(2);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        win_hit   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cells[i] == TILE_W'(WIN_VALUE)) win_hit = 1'b1;
            if (cells[i] == '0) any_empty = 1'b1;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (cells[4*r+c] == cells[4*r+c+1]) any_pair = 1'b1;
        for (int i = 0; i < 12; i++)
            if (cells[i] == cells[i+4]) any_pair = 1'b1;
    end

    // Move pulses are single-cycle strobes with no handshake: one is accepted
    // only in the cycle the engine is idle (busy low); pulses while busy are dropped.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            for (int i = 0; i < N_CELLS; i++) cells[i] <= '0;
            score       <= '0;
            win         <= 1'b0;
            game_over   <= 1'b0;
            lfsr        <= LFSR_SEED;
            state       <= ST_SPAWN;
            spawn_left  <= 2'd2;
            spawn_first <= 1'b1;
            ptr         <= '0;
            probes      <= '0;
            dir         <= DIR_UP;
            line        <= '0;
            changed     <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            if (load_en) begin
                for (int i = 0; i < N_CELLS; i++) cells[i] <= load_data[i*TILE_W +: TILE_W];
                score <= '0;
                win   <= 1'b0;
                state <= ST_FLAGS;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (btn_up || btn_down || btn_left || btn_right) begin
                            if (btn_up)        dir <= DIR_UP;
                            else if (btn_down) dir <= DIR_DOWN;
                            else if (btn_left) dir <= DIR_LEFT;
                            else               dir <= DIR_RIGHT;
                            line    <= '0;
                            changed <= 1'b0;
                            state   <= ST_MOVE;
                        end
                    end
                    ST_MOVE: begin
                        for (int k = 0; k < 4; k++)
                            cells[cell_index(dir, line, 2'(k))] <= line_out[k*TILE_W +: TILE_W];
                        changed <= changed | line_changed;
                        score   <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
                        line    <= line + 2'd1;
                        if (line == 2'd3) state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (changed) begin
                            state       <= ST_SPAWN;
                            spawn_left  <= 2'd1;
                            spawn_first <= 1'b1;
                        end else begin
                            state <= ST_FLAGS;
                        end
                    end
                    ST_SPAWN: begin
                        if (spawn_first) begin
                            ptr         <= lfsr[3:0];
                            probes      <= '0;
                            spawn_first <= 1'b0;
                        end else if (cells[ptr] == '0) begin
                            cells[ptr] <= spawn_val;
                            spawn_left <= spawn_left - 2'd1;
                            ptr        <= lfsr[3:0];
                            probes     <= '0;
                            if (spawn_left == 2'd1) state <= ST_FLAGS;
                        end else begin
                            // a full lap of occupied cells abandons the remaining spawns
                            ptr    <= ptr + 4'd1;
                            probes <= probes + 4'd1;
                            if (probes == 4'd15) state <= ST_FLAGS;
                        end
                    end
                    ST_FLAGS: begin
                        win       <= win | win_hit;
                        game_over <= !any_empty && !any_pair;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_move_engine.sv
// Bench for tile_move_engine: directed scenarios plus randomized boards checked
// against a queue-based model of the 2048 move rules.
module tb_tile_move_engine;
    import tile_pkg::*;

    typedef logic [11:0] board_t [16];

    logic         board_clk = 1'b0;
    logic         reset     = 1'b1;
    logic         btn_up    = 1'b0;
    logic         btn_down  = 1'b0;
    logic         btn_left  = 1'b0;
    logic         btn_right = 1'b0;
    logic         load_en   = 1'b0;
    logic [191:0] load_data = '0;
    logic [191:0] MatrixCopy;
    logic         busy;
    logic [19:0]  score;
    logic         win;
    logic         game_over;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];

    always #5 board_clk = ~board_clk;

    tile_move_engine dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .load_en    (load_en),
        .load_data  (load_data),
        .MatrixCopy (MatrixCopy),
        .busy       (busy),
        .score      (score),
        .win        (win),
        .game_over  (game_over)
    );

    // ---------------- reference model ----------------
    function automatic logic [191:0] pack(input board_t b);
        logic [191:0] v;
        for (int i = 0; i < 16; i++) v[i*12 +: 12] = b[i];
        return v;
    endfunction

    function automatic void unpack(input logic [191:0] v, output board_t b);
        for (int i = 0; i < 16; i++) b[i] = v[i*12 +: 12];
    endfunction

    function automatic void clear_board(output board_t b);
        for (int i = 0; i < 16; i++) b[i] = '0;
    endfunction

    // Slide every line toward the destination edge; merged value wraps at 12 bits.
    function automatic void model_move(input board_t bi, input logic [1:0] d,
                                       output board_t bo, output int gain);
        int idx[4];
        int vals[$];
        int res[$];
        int i;
        gain = 0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int k = 0; k < 4; k++) begin
                if (d == DIR_LEFT)       idx[k] = ln * 4 + k;
                else if (d == DIR_RIGHT) idx[k] = ln * 4 + (3 - k);
                else if (d == DIR_UP)    idx[k] = k * 4 + ln;
                else                     idx[k] = (3 - k) * 4 + ln;
            end
            vals.delete();
            res.delete();
            for (int k = 0; k < 4; k++) if (bi[idx[k]] != 0) vals.push_back(int'(bi[idx[k]]));
            i = 0;
            while (i < vals.size()) begin
                if (i + 1 < vals.size() && vals[i] == vals[i+1]) begin
                    res.push_back((vals[i] * 2) % 4096);
                    gain += (vals[i] * 2) % 4096;
                    i += 2;
                end else begin
                    res.push_back(vals[i]);
                    i += 1;
                end
            end
            for (int k = 0; k < 4; k++) bo[idx[k]] = (k < res.size()) ? 12'(res[k]) : 12'd0;
        end
    endfunction

    function automatic bit model_over(input board_t b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (b[r*4+c] == 0) return 1'b0;
                if (c < 3 && b[r*4+c] == b[r*4+c+1]) return 1'b0;
                if (r < 3 && b[r*4+c] == b[(r+1)*4+c]) return 1'b0;
            end
        return 1'b1;
    endfunction

    // Cells differing from exp: legal spawns (empty -> 2/4) vs anything else.
    function automatic void diff_spawn(input board_t act, input board_t exp_b,
                                       output int spawns, output int bad);
        spawns = 0;
        bad    = 0;
        for (int i = 0; i < 16; i++)
            if (act[i] !== exp_b[i]) begin
                if (exp_b[i] == 0 && (act[i] == 12'd2 || act[i] == 12'd4)) spawns++;
                else bad++;
            end
    endfunction

    function automatic void count_tiles(input board_t b, output int tiles, output int odd);
        tiles = 0;
        odd   = 0;
        for (int i = 0; i < 16; i++)
            if (b[i] != 0) begin
                tiles++;
                if (b[i] != 12'd2 && b[i] != 12'd4) odd++;
            end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_btn(input logic [1:0] d, input logic v);
        btn_up    = v && (d == DIR_UP);
        btn_down  = v && (d == DIR_DOWN);
        btn_left  = v && (d == DIR_LEFT);
        btn_right = v && (d == DIR_RIGHT);
    endtask

    task automatic do_load(input board_t b);
        @(negedge board_clk);
        load_en   = 1'b1;
        load_data = pack(b);
        @(negedge board_clk);
        load_en = 1'b0;
        @(negedge board_clk);
    endtask

    task automatic do_move(input logic [1:0] d, output int cyc);
        @(negedge board_clk);
        set_btn(d, 1'b1);
        @(negedge board_clk);
        set_btn(d, 1'b0);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge board_clk);
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            @(negedge board_clk);
            cyc++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        board_t act;
        int cyc, tiles, odd;
        reset = 1'b1;
        repeat (3) @(negedge board_clk);
        n_cmp++; if (MatrixCopy !== '0) begin n_bad++; $display("FAIL reset_board: got %h expected 0", MatrixCopy); end
        n_cmp++; if (score !== 20'd0) begin n_bad++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_cmp++; if (win !== 1'b0 || game_over !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got win=%b go=%b expected 0 0", win, game_over); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
        reset = 1'b0;
        wait_idle(cyc);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_timeout: busy still %b after %0d cycles", busy, cyc); end
        unpack(MatrixCopy, act);
        count_tiles(act, tiles, odd);
        n_cmp++; if (tiles !== 2 || odd !== 0) begin n_bad++; $display("FAIL reset_spawn: got %0d tiles (%0d bad values) expected 2 of 2/4", tiles, odd); end
    endtask

    task automatic test_merge_left();
        board_t b, exp_b, act;
        int cyc, sp, bad;
        clear_board(b);
        for (int i = 0; i < 4; i++) b[i] = 12'd2;
        do_load(b);
        do_move(DIR_LEFT, cyc);
        clear_board(exp_b);
        exp_b[0] = 12'd4;
        exp_b[1] = 12'd4;
        unpack(MatrixCopy, act);
        diff_spawn(act, exp_b, sp, bad);
        n_cmp++; if (bad !== 0 || sp !== 1) begin n_bad++; $display("FAIL left_board: got %0d wrong cells, %0d spawns expected 0, 1", bad, sp); end
        n_cmp++; if (score !== 20'd8) begin n_bad++; $display("FAIL left_score: got %0d expected 8", score); end
        n_cmp++; if (cyc < 8 || cyc > 23) begin n_bad++; $display("FAIL left_busy: got %0d cycles expected 8..23", cyc); end
    endtask

    task automatic test_merge_up();
        board_t b, exp_b, act;
        int cyc, sp, bad;
        clear_board(b);
        b[0] = 12'd2;
        b[4] = 12'd2;
        b[8] = 12'd4;
        do_load(b);
        do_move(DIR_UP, cyc);
        clear_board(exp_b);
        exp_b[0] = 12'd4;
        exp_b[4] = 12'd4;
        unpack(MatrixCopy, act);
        diff_spawn(act, exp_b, sp, bad);
        n_cmp++; if (bad !== 0 || sp !== 1) begin n_bad++; $display("FAIL up_board: got %0d wrong cells, %0d spawns expected 0, 1", bad, sp); end
        n_cmp++; if (score !== 20'd4) begin n_bad++; $display("FAIL up_score: got %0d expected 4", score); end
    endtask

    task automatic test_no_change();
        board_t b;
        int cyc;
        clear_board(b);
        b[0] = 12'd2;
        b[1] = 12'd4;
        b[2] = 12'd8;
        b[3] = 12'd16;
        do_load(b);
        do_move(DIR_LEFT, cyc);
        n_cmp++; if (MatrixCopy !== pack(b)) begin n_bad++; $display("FAIL nochange_board: got %h expected %h", MatrixCopy, pack(b)); end
        n_cmp++; if (score !== 20'd0) begin n_bad++; $display("FAIL nochange_score: got %0d expected 0", score); end
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL nochange_busy: got %0d cycles expected 6", cyc); end
    endtask

    task automatic test_win();
        board_t b, act;
        int cyc;
        clear_board(b);
        b[0] = 12'd1024;
        b[1] = 12'd1024;
        do_load(b);
        n_cmp++; if (win !== 1'b0) begin n_bad++; $display("FAIL win_after_load: got %b expected 0", win); end
        do_move(DIR_LEFT, cyc);
        unpack(MatrixCopy, act);
        n_cmp++; if (act[0] !== 12'd2048) begin n_bad++; $display("FAIL win_cell0: got %0d expected 2048", act[0]); end
        n_cmp++; if (score !== 20'd2048) begin n_bad++; $display("FAIL win_score: got %0d expected 2048", score); end
        n_cmp++; if (win !== 1'b1) begin n_bad++; $display("FAIL win_flag: got %b expected 1", win); end
        do_move(DIR_RIGHT, cyc);
        n_cmp++; if (win !== 1'b1) begin n_bad++; $display("FAIL win_sticky: got %b expected 1", win); end
    endtask

    task automatic test_game_over();
        board_t b;
        int cyc;
        for (int i = 0; i < 16; i++) b[i] = (((i >> 2) + (i & 3)) % 2 == 0) ? 12'd2 : 12'd4;
        do_load(b);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL over_after_load: got %b expected 1", game_over); end
        do_move(DIR_UP, cyc);
        n_cmp++; if (MatrixCopy !== pack(b)) begin n_bad++; $display("FAIL over_board: got %h expected %h", MatrixCopy, pack(b)); end
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL over_busy: got %0d cycles expected 6", cyc); end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL over_sticky: got %b expected 1", game_over); end
    endtask

    task automatic test_reset_mid_move();
        board_t b, act;
        int cyc, tiles, odd;
        clear_board(b);
        b[0] = 12'd2;
        b[1] = 12'd2;
        b[6] = 12'd8;
        do_load(b);
        @(negedge board_clk);
        set_btn(DIR_LEFT, 1'b1);
        @(negedge board_clk);
        set_btn(DIR_LEFT, 1'b0);
        @(negedge board_clk);
        reset = 1'b1;
        @(negedge board_clk);
        reset = 1'b0;
        n_cmp++; if (MatrixCopy !== '0) begin n_bad++; $display("FAIL midreset_board: got %h expected 0", MatrixCopy); end
        n_cmp++; if (busy !== 1'b1 || score !== 20'd0) begin n_bad++; $display("FAIL midreset_state: got busy=%b score=%0d expected 1, 0", busy, score); end
        set_btn(DIR_LEFT, 1'b1);
        @(negedge board_clk);
        set_btn(DIR_LEFT, 1'b0);
        wait_idle(cyc);
        unpack(MatrixCopy, act);
        count_tiles(act, tiles, odd);
        n_cmp++; if (tiles !== 2 || odd !== 0) begin n_bad++; $display("FAIL midreset_spawn: got %0d tiles (%0d bad values) expected 2 of 2/4", tiles, odd); end
        @(negedge board_clk);
        n_cmp++; if (busy !== 1'b0 || MatrixCopy !== pack(act)) begin n_bad++; $display("FAIL midreset_ignored_btn: got busy=%b expected 0 with board unchanged", busy); end
    endtask

    task automatic test_random(input int iters);
        board_t b, bo, act;
        logic [1:0] d;
        int gain, cyc, sp, bad;
        bit chg;
        logic [11:0] e;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 16; i++)
                b[i] = ($urandom_range(0, 2) == 0) ? 12'd0 : (12'd1 << $urandom_range(1, 3));
            do_load(b);
            n_cmp++; if (game_over !== model_over(b)) begin n_bad++; $display("FAIL rand_over_load[%0d]: got %b expected %b", it, game_over, model_over(b)); end
            d = 2'($urandom_range(0, 3));
            model_move(b, d, bo, gain);
            chg = 1'b0;
            for (int i = 0; i < 16; i++) if (bo[i] != b[i]) chg = 1'b1;
            do_move(d, cyc);
            for (int i = 0; i < 16; i++) exp_q.push_back(bo[i]);
            unpack(MatrixCopy, act);
            sp  = 0;
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                e = exp_q.pop_front();
                if (act[i] !== e) begin
                    if (e == 0 && (act[i] == 12'd2 || act[i] == 12'd4)) sp++;
                    else bad++;
                end
            end
            n_cmp++; if (bad !== 0 || sp !== int'(chg)) begin n_bad++; $display("FAIL rand_board[%0d] dir=%0d: got %0d wrong cells, %0d spawns expected 0, %0d", it, d, bad, sp, chg); end
            n_cmp++; if (score !== 20'(gain)) begin n_bad++; $display("FAIL rand_score[%0d]: got %0d expected %0d", it, score, gain); end
            n_cmp++; if (chg ? (cyc < 8 || cyc > 23) : (cyc !== 6)) begin n_bad++; $display("FAIL rand_busy[%0d]: got %0d cycles changed=%0d", it, cyc, chg); end
            n_cmp++; if (game_over !== model_over(act)) begin n_bad++; $display("FAIL rand_over[%0d]: got %b expected %b", it, game_over, model_over(act)); end
        end
    endtask

    initial begin
        test_reset();
        test_merge_left();
        test_merge_up();
        test_no_change();
        test_win();
        test_game_over();
        test_reset_mid_move();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
